// File: rtl/multicycle_control_unit.sv
// Sequencer for the multi-cycle RV32I datapath: steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives all datapath controls.
module multicycle_control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_src,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        alu_out_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_src,
    output logic        alu_b_src,
    output logic [3:0]  alu_op,
    output logic [2:0]  imm_src,
    output logic [4:0]  br_op,
    output logic [2:0]  dm_ctrl,
    output logic        ru_wr,
    output logic [1:0]  ru_data_wr_src,
    output logic        retire,
    output logic        trap,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    state_t st;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic       legal, is_jump;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign f7b5     = instr[30];
    assign is_r     = (opcode == 7'b0110011);
    assign is_i     = (opcode == 7'b0010011);
    assign is_ld    = (opcode == 7'b0000011);
    assign is_st    = (opcode == 7'b0100011);
    assign is_br    = (opcode == 7'b1100011);
    assign is_jal   = (opcode == 7'b1101111);
    assign is_jalr  = (opcode == 7'b1100111);
    assign is_lui   = (opcode == 7'b0110111);
    assign is_auipc = (opcode == 7'b0010111);
    assign is_jump  = is_jal | is_jalr;
    assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jump | is_lui | is_auipc;
    assign state    = st;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= S_IDLE;
        end else begin
            case (st)
                S_IDLE:      st <= S_FETCH;
                S_FETCH:     if (mem_ready) st <= S_DECODE;
                S_DECODE:    st <= legal ? S_EXECUTE : S_TRAP;
                S_EXECUTE: begin
                    if (is_ld || is_st) st <= S_MEMORY;
                    else if (is_br)     st <= S_FETCH;
                    else                st <= S_WRITEBACK;
                end
                S_MEMORY:    if (mem_ready) st <= is_st ? S_FETCH : S_WRITEBACK;
                S_WRITEBACK: st <= S_FETCH;
                S_TRAP:      st <= S_TRAP;
                default:     st <= S_IDLE;
            endcase
        end
    end

    // Everything is a function of state and the latched instruction; only the
    // memory handshake strobes and the branch PC select also see live inputs.
    always_comb begin
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr_src   = 1'b0;
        ir_we          = 1'b0;
        mdr_we         = 1'b0;
        alu_out_we     = 1'b0;
        pc_we          = 1'b0;
        pc_src         = 2'b00;
        alu_a_src      = 2'b00;
        alu_b_src      = 1'b0;
        alu_op         = 4'b0000;
        imm_src        = 3'b000;
        br_op          = 5'b00000;
        dm_ctrl        = 3'b000;
        ru_wr          = 1'b0;
        ru_data_wr_src = 2'b00;
        retire         = 1'b0;
        trap           = 1'b0;
        case (st)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXECUTE: begin
                alu_out_we = 1'b1;
                alu_b_src  = ~is_r;
                if (is_br || is_jal || is_auipc) alu_a_src = 2'b01;
                else if (is_lui)                 alu_a_src = 2'b10;
                if (is_r)      alu_op = {f7b5, funct3};
                else if (is_i) alu_op = (funct3 == 3'b101) ? {f7b5, funct3} : {1'b0, funct3};
                if (is_st)                  imm_src = 3'b001;
                else if (is_br)             imm_src = 3'b101;
                else if (is_jal)            imm_src = 3'b110;
                else if (is_lui || is_auipc) imm_src = 3'b010;
                if (is_jump || is_br) br_op = {is_jump, is_br, funct3};
                if (is_br) begin
                    pc_we  = 1'b1;
                    pc_src = br_taken ? 2'b01 : 2'b00;
                    retire = 1'b1;
                end
            end
            S_MEMORY: begin
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                mem_we       = is_st;
                dm_ctrl      = funct3;
                pc_we        = mem_ready & is_st;
                retire       = mem_ready & is_st;
                mdr_we       = mem_ready & ~is_st;
            end
            S_WRITEBACK: begin
                ru_wr          = 1'b1;
                pc_we          = 1'b1;
                retire         = 1'b1;
                ru_data_wr_src = is_ld ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
                pc_src         = is_jump ? 2'b10 : 2'b00;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end
endmodule
